ht_sort_engine: RTL and testbench

//  Parametrised array-capture-and-sort engine; next generation of the hackathon capture block.
//  On start, latches N elements of W bits and sorts them with odd-even transposition (N passes).

---
 rtl/ht_sort_engine.sv | 126 ++++++++++++
 tb/tb_ht_sort_engine.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/ht_sort_engine.sv
// rtl/ht_sort_engine.sv - capture N elements and sort them by odd-even transposition (HT_SIGNED_EN selects signed compare)
module ht_sort_engine #(
  parameter int N = 8,
  parameter int W = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic           descend,
  input  logic [N*W-1:0] in_data,
  output logic [N*W-1:0] out_data,
  output logic           out_valid,
  output logic           busy,
  output logic           over
);

  // Pass counter must be able to hold N-1 without wrapping.
  localparam int PW = $clog2(N + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SORT,
    S_DONE
  } state_t;

  state_t          state_q;
  logic [W-1:0]    elem_q [N];
  logic [W-1:0]    elem_d [N];
  logic [PW-1:0]   pass_q;
  logic            descend_q;
  logic            out_valid_q;
  logic            busy_q;
  logic            over_q;

  // Strict greater-than; the only place the signedness option matters.
  function automatic logic greater(input logic [W-1:0] a, input logic [W-1:0] b);
`ifdef HT_SIGNED_EN
    return $signed(a) > $signed(b);
`else
    return a > b;
`endif
  endfunction

  // One compare-exchange phase: even passes pair (0,1),(2,3)..., odd passes pair (1,2),(3,4)...
  // Pairs within a phase are disjoint, so every swap reads only elem_q.
  // Strict compare keeps equal elements in place, which makes the sort stable.
  always_comb begin
    for (int k = 0; k < N; k++) begin
      elem_d[k] = elem_q[k];
    end
    for (int i = 0; i < N - 1; i++) begin
      if (((i % 2) == 1) == pass_q[0]) begin
        if (descend_q ? greater(elem_q[i+1], elem_q[i]) : greater(elem_q[i], elem_q[i+1])) begin
          elem_d[i]   = elem_q[i+1];
          elem_d[i+1] = elem_q[i];
        end
      end
    end
  end

  // Control FSM and all registered outputs; start is only honoured in IDLE (DONE counts as busy).
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      pass_q      <= '0;
      descend_q   <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      over_q      <= 1'b0;
      for (int k = 0; k < N; k++) begin
        elem_q[k] <= '0;
      end
    end else begin
      case (state_q)
        S_IDLE: begin
          over_q <= 1'b0;
          if (start) begin
            for (int k = 0; k < N; k++) begin
              elem_q[k] <= in_data[k*W +: W];
            end
            descend_q   <= descend;
            pass_q      <= '0;
            busy_q      <= 1'b1;
            out_valid_q <= 1'b0;
            state_q     <= S_SORT;
          end
        end
        S_SORT: begin
          for (int k = 0; k < N; k++) begin
            elem_q[k] <= elem_d[k];
          end
          if (pass_q == PW'(N - 1)) begin
            state_q     <= S_DONE;
            over_q      <= 1'b1;
            out_valid_q <= 1'b1;
            busy_q      <= 1'b0;
          end else begin
            pass_q <= pass_q + 1'b1;
          end
        end
        S_DONE: begin
          over_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          over_q  <= 1'b0;
        end
      endcase
    end
  end

  // The output array is the working register set itself; it stays put between over and the next start.
  always_comb begin
    out_data = '0;
    for (int k = 0; k < N; k++) begin
      out_data[k*W +: W] = elem_q[k];
    end
  end

  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign over      = over_q;

endmodule

// File: tb/tb_ht_sort_engine.sv
// tb/tb_ht_sort_engine.sv - directed bench for ht_sort_engine (N=8/W=8 and N=1/W=4 instances)
module tb_ht_sort_engine;

  logic        clk;
  logic        rst;
  logic        start;
  logic        descend;
  logic [63:0] in_data;
  logic [63:0] out_data;
  logic        out_valid;
  logic        busy;
  logic        over;

  logic        s_start;
  logic        s_descend;
  logic [3:0]  s_in_data;
  logic [3:0]  s_out_data;
  logic        s_out_valid;
  logic        s_busy;
  logic        s_over;

  int total;
  int bad;
  int cyc;
  int cnt;

  ht_sort_engine #(.N(8), .W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .descend(descend), .in_data(in_data),
    .out_data(out_data), .out_valid(out_valid), .busy(busy), .over(over)
  );

  ht_sort_engine #(.N(1), .W(4)) dut1 (
    .clk(clk), .rst(rst), .start(s_start), .descend(s_descend), .in_data(s_in_data),
    .out_data(s_out_data), .out_valid(s_out_valid), .busy(s_busy), .over(s_over)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance until over is seen; cyc counts cycles since the start edge (bounded).
  task automatic wait_over(input int c0, output int c);
    c = c0;
    while (over !== 1'b1 && c < 40) begin
      tick();
      c++;
    end
  endtask

  initial begin
    total = 0;
    bad = 0;
    rst = 1'b1;
    start = 1'b0;
    descend = 1'b0;
    in_data = '0;
    s_start = 1'b0;
    s_descend = 1'b0;
    s_in_data = '0;
    tick();
    tick();
    chk("rst_out_data", out_data, 64'h0);
    chk("rst_out_valid", {63'b0, out_valid}, 64'h0);
    chk("rst_busy", {63'b0, busy}, 64'h0);
    chk("rst_over", {63'b0, over}, 64'h0);
    rst = 1'b0;
    tick();

    // Scenario 1: reverse ascending input, ascending sort
    in_data = 64'h0001020304050607;
    descend = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    in_data = 64'hDEADBEEFCAFEF00D;
    chk("s1_busy", {63'b0, busy}, 64'h1);
    chk("s1_valid_cleared", {63'b0, out_valid}, 64'h0);
    wait_over(1, cyc);
    chk("s1_latency", 64'(cyc), 64'd9);
    chk("s1_out", out_data, 64'h0706050403020100);
    chk("s1_valid", {63'b0, out_valid}, 64'h1);
    chk("s1_busy_done", {63'b0, busy}, 64'h0);
    tick();
    chk("s1_over_pulse", {63'b0, over}, 64'h0);

    // Scenario 2: duplicates, descending sort
    in_data = 64'h0202000901030903;
    descend = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    descend = 1'b0;
    chk("s2_valid_cleared", {63'b0, out_valid}, 64'h0);
    wait_over(1, cyc);
    chk("s2_latency", 64'(cyc), 64'd9);
    chk("s2_out", out_data, 64'h0001020203030909);
    tick();
    chk("s2_over_width", {63'b0, over}, 64'h0);
    chk("s2_busy_after", {63'b0, busy}, 64'h0);
    chk("s2_out_held", out_data, 64'h0001020203030909);

    // Scenario 3: starts at t+3 and t+9 are ignored
    in_data = 64'h0001020304050607;
    descend = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    in_data = 64'h1122334455667788;
    descend = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_over(4, cyc);
    chk("s3_latency", 64'(cyc), 64'd9);
    chk("s3_out", out_data, 64'h0706050403020100);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("s3_busy_after_done_start", {63'b0, busy}, 64'h0);
    chk("s3_valid_kept", {63'b0, out_valid}, 64'h1);
    chk("s3_out_kept", out_data, 64'h0706050403020100);
    tick();
    chk("s3_still_idle", {63'b0, busy}, 64'h0);

    // Scenario 4: reset mid-sort
    in_data = 64'h0202000901030903;
    descend = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("s4_out_data", out_data, 64'h0);
    chk("s4_valid", {63'b0, out_valid}, 64'h0);
    chk("s4_busy", {63'b0, busy}, 64'h0);
    cnt = 0;
    for (int i = 0; i < 12; i++) begin
      if (over === 1'b1) cnt++;
      tick();
    end
    chk("s4_no_over", 64'(cnt), 64'd0);

    // Scenario 5: sign-sensitive values
    in_data = 64'h0000000001FF7F80;
    descend = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_over(1, cyc);
    chk("s5_latency", 64'(cyc), 64'd9);
`ifdef HT_SIGNED_EN
    chk("s5_out_signed", out_data, 64'h7F0100000000FF80);
`else
    chk("s5_out_unsigned", out_data, 64'hFF807F0100000000);
`endif

    // Scenario 6: N=1 passes the single element through
    s_in_data = 4'hA;
    s_start = 1'b1;
    tick();
    s_start = 1'b0;
    s_in_data = 4'h3;
    chk("s6_busy", {63'b0, s_busy}, 64'h1);
    chk("s6_over_early", {63'b0, s_over}, 64'h0);
    tick();
    chk("s6_over", {63'b0, s_over}, 64'h1);
    chk("s6_out", {60'b0, s_out_data}, 64'hA);
    chk("s6_valid", {63'b0, s_out_valid}, 64'h1);
    tick();
    chk("s6_over_drop", {63'b0, s_over}, 64'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
